// File: rtl/prog_interval_timer.sv
// prog_interval_timer: multi-channel programmable down-counter timer with shared prescaler
module prog_interval_timer #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 3,
    parameter int PRESCALE = 1,
    parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [SELW-1:0]     wr_sel,
    input  logic [1:0]          wr_mode,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [CHANNELS-1:0] gate,
    input  logic [SELW-1:0]     rd_sel,
    output logic [WIDTH-1:0]    rd_count,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] irq
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [1:0] M_ONE = 2'd0, M_RATE = 2'd1, M_SQ = 2'd2, M_OFF = 2'd3;

    logic [PW-1:0]                  pre_q, pre_d;
    logic                           tick;
    logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d, rel_q, rel_d;
    logic [CHANNELS-1:0][1:0]       mode_q, mode_d;
    logic [CHANNELS-1:0]            run_q, run_d, out_q, out_d, irq_q, irq_d, en, term;

    // a zero count or reload stands for 2^WIDTH
    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v);
        return (v == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, v};
    endfunction

    // prescaler wraps at PRESCALE-1 and emits the shared count tick there
    always_comb begin
        tick  = pre_q == PW'(PRESCALE - 1);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // per-channel next state: decrement/reload, output level, terminal pulse; a write overrides all
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            en[i]     = tick & gate[i] & run_q[i];
            term[i]   = en[i] & (cnt_q[i] == WIDTH'(1));
            rel_d[i]  = rel_q[i];
            mode_d[i] = mode_q[i];
            cnt_d[i]  = !en[i] ? cnt_q[i] :
                        (term[i] && mode_q[i] != M_ONE) ? rel_q[i] : cnt_q[i] - 1'b1;
            run_d[i]  = run_q[i] & ~(term[i] & (mode_q[i] == M_ONE));
            irq_d[i]  = term[i];
            out_d[i]  = (mode_q[i] == M_ONE)  ? (out_q[i] | term[i]) :
                        (mode_q[i] == M_RATE) ? ~term[i] :
                        (mode_q[i] == M_SQ)   ? (ext(cnt_d[i]) > (ext(rel_q[i]) >> 1)) : 1'b0;
            if (wr_en && wr_sel == SELW'(i)) begin
                rel_d[i]  = wr_data;
                mode_d[i] = wr_mode;
                cnt_d[i]  = wr_data;
                run_d[i]  = wr_mode != M_OFF;
                out_d[i]  = (wr_mode == M_RATE) || (wr_mode == M_SQ);
                irq_d[i]  = 1'b0;
            end
        end
    end

    // state registers, asynchronously cleared to disabled idle channels
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            rel_q  <= '0;
            mode_q <= '1;
            run_q  <= '0;
            out_q  <= '0;
            irq_q  <= '0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            rel_q  <= rel_d;
            mode_q <= mode_d;
            run_q  <= run_d;
            out_q  <= out_d;
            irq_q  <= irq_d;
        end
    end

    // count read-back; selects beyond the last channel read as zero
    always_comb begin
        rd_count = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (rd_sel == SELW'(i)) rd_count = cnt_q[i];
    end

    assign out = out_q;
    assign irq = irq_q;
endmodule

// File: tb/tb_prog_interval_timer.sv
// tb_prog_interval_timer: scoreboard bench for the interval timer (default build plus a 4-bit, prescale-3 build)
module tb_prog_interval_timer;
    logic        clk_in = 0, rst = 1;
    logic        wr_en = 0;
    logic [1:0]  wr_sel = 0, wr_mode = 0, rd_sel = 0;
    logic [15:0] wr_data = 0, rd_count;
    logic [2:0]  gate = 3'b111, out, irq;
    logic        b_wr_en = 0, b_wr_sel = 0, b_rd_sel = 0;
    logic [1:0]  b_wr_mode = 0, b_gate = 2'b11, b_out, b_irq;
    logic [3:0]  b_wr_data = 0, b_rd_count;

    int cyc = 0, checks = 0, passed = 0, rel = 0, w = 0, t1 = 0;

    typedef struct {int cyc; int kind; int val;} lvl_t;
    typedef struct {int cyc; int mask;} irq_t;
    lvl_t lvl_q[$];
    irq_t irq_q[$];

    prog_interval_timer dut (
        .clk_in(clk_in), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_mode(wr_mode),
        .wr_data(wr_data), .gate(gate), .rd_sel(rd_sel), .rd_count(rd_count), .out(out), .irq(irq)
    );

    prog_interval_timer #(.WIDTH(4), .CHANNELS(2), .PRESCALE(3)) dut_b (
        .clk_in(clk_in), .rst(rst), .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_mode(b_wr_mode),
        .wr_data(b_wr_data), .gate(b_gate), .rd_sel(b_rd_sel), .rd_count(b_rd_count), .out(b_out), .irq(b_irq)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // monitor: irq pulses pop the irq scoreboard, level expectations pop when their cycle arrives
    always @(negedge clk_in) begin
        logic [4:0] all_irq;
        lvl_t e;
        int act;
        all_irq = {b_irq, irq};
        while (irq_q.size() != 0 && irq_q[0].cyc < cyc) begin
            checks++;
            $display("FAIL irq_missed cyc=%0d actual=none required=%b", irq_q[0].cyc, irq_q[0].mask[4:0]);
            void'(irq_q.pop_front());
        end
        if (all_irq != 0) begin
            checks++;
            if (irq_q.size() != 0 && irq_q[0].cyc == cyc && irq_q[0].mask == int'(all_irq)) passed++;
            else $display("FAIL irq cyc=%0d actual=%b required=%0s", cyc, all_irq,
                          (irq_q.size() != 0 && irq_q[0].cyc == cyc) ? $sformatf("%b", irq_q[0].mask[4:0]) : "none");
            if (irq_q.size() != 0 && irq_q[0].cyc == cyc) void'(irq_q.pop_front());
        end
        while (lvl_q.size() != 0 && lvl_q[0].cyc <= cyc) begin
            e = lvl_q.pop_front();
            act = (e.kind == 0) ? int'(out) : (e.kind == 1) ? int'(rd_count) :
                  (e.kind == 2) ? int'(b_out) : int'(b_rd_count);
            checks++;
            if (e.cyc == cyc && act == e.val) passed++;
            else $display("FAIL %0s cyc=%0d (now %0d) actual=%0d required=%0d",
                          e.kind == 0 ? "out" : e.kind == 1 ? "rd_count" : e.kind == 2 ? "b_out" : "b_rd_count",
                          e.cyc, cyc, act, e.val);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic wr(input int sel, input int mode, input int data);
        wr_sel = 2'(sel); wr_mode = 2'(mode); wr_data = 16'(data); wr_en = 1;
        step(1);
        wr_en = 0;
    endtask

    task automatic bwr(input int sel, input int mode, input int data);
        b_wr_sel = 1'(sel); b_wr_mode = 2'(mode); b_wr_data = 4'(data); b_wr_en = 1;
        step(1);
        b_wr_en = 0;
    endtask

    task automatic exp_lvl(input int c, input int k, input int v);
        lvl_q.push_back('{c, k, v});
    endtask

    task automatic exp_irq(input int c, input int m);
        irq_q.push_back('{c, m});
    endtask

    initial begin
        // power-on reset
        exp_lvl(1, 0, 0); exp_lvl(1, 1, 0); exp_lvl(1, 2, 0); exp_lvl(1, 3, 0);
        step(2);
        rst = 0; rel = cyc;

        // asynchronous reset in the middle of a rate count
        rd_sel = 0;
        wr(0, 1, 10);
        step(3);
        exp_lvl(cyc, 0, 0); exp_lvl(cyc, 1, 0);
        rst = 1;
        step(1);
        rst = 0; rel = cyc;
        step(25);

        // rate mode, ch1 R=4
        rd_sel = 1;
        wr(1, 1, 4); w = cyc;
        for (int k = 1; k <= 12; k++) begin
            exp_lvl(w + k, 0, (k % 4 == 0) ? 0 : 2);
            exp_lvl(w + k, 1, 4 - (k % 4));
            if (k % 4 == 0) exp_irq(w + k, 2);
        end
        step(12);
        wr(1, 3, 0);

        // square mode, ch2 R=5 then R=4
        rd_sel = 2;
        wr(2, 2, 5); w = cyc;
        for (int k = 1; k <= 10; k++) begin
            exp_lvl(w + k, 0, (k % 5 < 3) ? 4 : 0);
            exp_lvl(w + k, 1, 5 - (k % 5));
            if (k % 5 == 0) exp_irq(w + k, 4);
        end
        step(10);
        wr(2, 2, 4); w = cyc;
        exp_lvl(w, 1, 4);
        for (int k = 1; k <= 8; k++) begin
            exp_lvl(w + k, 0, (k % 4 < 2) ? 4 : 0);
            exp_lvl(w + k, 1, 4 - (k % 4));
            if (k % 4 == 0) exp_irq(w + k, 4);
        end
        step(8);
        wr(2, 3, 0);

        // one-shot, ch0 R=3, gate dropped for two cycles after the first decrement
        rd_sel = 0;
        wr(0, 0, 3); w = cyc;
        for (int k = 1; k <= 10; k++) begin
            exp_lvl(w + k, 0, (k >= 5) ? 1 : 0);
            exp_lvl(w + k, 1, (k < 4) ? 2 : (k == 4) ? 1 : 0);
        end
        exp_irq(w + 5, 1);
        step(1);
        gate = 3'b110;
        step(2);
        gate = 3'b111;
        step(7);
        wr(0, 0, 3); w = cyc;
        exp_lvl(w, 0, 0); exp_lvl(w, 1, 3);
        for (int k = 1; k <= 3; k++) begin
            exp_lvl(w + k, 0, (k == 3) ? 1 : 0);
            exp_lvl(w + k, 1, 3 - k);
        end
        exp_irq(w + 3, 1);
        step(4);
        wr(0, 3, 0);

        // write colliding with term on ch1
        rd_sel = 1;
        wr(1, 1, 4); w = cyc;
        for (int k = 1; k <= 3; k++) exp_lvl(w + k, 1, 4 - k);
        step(3);
        wr(1, 1, 7);
        exp_lvl(w + 4, 0, 2); exp_lvl(w + 4, 1, 7); exp_lvl(w + 5, 1, 6);
        exp_irq(w + 11, 2);
        step(7);
        wr(1, 3, 0);

        // disabled mode holds its count; out-of-range select for read and write
        rd_sel = 0;
        wr(0, 3, 9);
        exp_lvl(cyc, 1, 9);
        step(1);
        rd_sel = 3;
        exp_lvl(cyc, 1, 0);
        step(1);
        wr(3, 1, 5);
        rd_sel = 0;
        exp_lvl(cyc, 0, 0); exp_lvl(cyc, 1, 9);
        step(1);
        rd_sel = 1;
        exp_lvl(cyc, 1, 0);
        step(1);
        rd_sel = 2;
        exp_lvl(cyc, 0, 0); exp_lvl(cyc, 1, 0);
        step(3);
        rd_sel = 0;
        exp_lvl(cyc, 0, 0); exp_lvl(cyc, 1, 9);
        step(1);

        // 4-bit, prescale-3 build: R=2 gives a 6-cycle period
        b_rd_sel = 0;
        bwr(0, 1, 2); w = cyc;
        t1 = w + 1;
        while ((t1 - rel) % 3 != 0) t1++;
        exp_lvl(w, 3, 2); exp_lvl(t1, 3, 1);
        exp_irq(t1 + 3, 8); exp_lvl(t1 + 3, 2, 0); exp_lvl(t1 + 4, 2, 1);
        exp_irq(t1 + 9, 8); exp_irq(t1 + 15, 8);
        step(t1 + 15 - cyc);
        bwr(0, 3, 0);

        // 4-bit build, R=0 wraps to a 16-tick (48-cycle) period
        b_rd_sel = 1;
        bwr(1, 1, 0); w = cyc;
        t1 = w + 1;
        while ((t1 - rel) % 3 != 0) t1++;
        exp_lvl(w, 3, 0); exp_lvl(t1, 3, 15);
        exp_irq(t1 + 45, 16); exp_irq(t1 + 93, 16);
        step(t1 + 93 - cyc);
        bwr(1, 3, 0);

        for (int i = 0; i < 20 && (irq_q.size() != 0 || lvl_q.size() != 0); i++) step(1);
        while (irq_q.size() != 0) begin
            checks++;
            $display("FAIL irq_pending cyc=%0d actual=none required=%b", irq_q[0].cyc, irq_q[0].mask[4:0]);
            void'(irq_q.pop_front());
        end
        while (lvl_q.size() != 0) begin
            checks++;
            $display("FAIL level_pending cyc=%0d kind=%0d actual=unchecked required=%0d",
                     lvl_q[0].cyc, lvl_q[0].kind, lvl_q[0].val);
            void'(lvl_q.pop_front());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
